// File: rtl/pico_issue_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : pico_issue_driver_if
// Description : Pin-level bus between the issue driver and the pico core.
//               master = issue driver, slave = core (or core model).
// Revision    : 1.0 - initial release
// ============================================================================
interface pico_issue_driver_if;
  logic [7:0] core_ui;   // bit7 strobe, [6:0] instruction low bits
  logic [7:0] core_uio;  // instruction high bits
  logic [7:0] core_uo;   // result byte from the core
  logic [7:0] core_dbg;  // bit3 valid, [2:0] rd

  modport master (output core_ui, output core_uio, input core_uo, input core_dbg);
  modport slave  (input core_ui, input core_uio, output core_uo, output core_dbg);
endinterface
`default_nettype wire

// File: rtl/pico_issue_driver.sv
`default_nettype none
// ============================================================================
// Module      : pico_issue_driver
// Description : Host-side initiator for the pico core instruction interface.
//               Issues a stored program one 15-bit word at a time using the
//               ui[7] strobe protocol, waits for the core valid flag and
//               captures each result byte into a result memory.
//               Optional macro STEP_MODE_EN adds single-step (HOLD) support.
// Revision    : 1.0 - initial release
// ============================================================================
module pico_issue_driver #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int SETTLE  = 1,
  parameter int TIMEOUT = 15
) (
  input  wire           clk,
  input  wire           rst,
  input  wire           prog_we,
  input  wire  [AW-1:0] prog_addr,
  input  wire  [14:0]   prog_wdata,
  input  wire  [AW:0]   prog_len,
  input  wire           start,
  input  wire           abort,
`ifdef STEP_MODE_EN
  input  wire           step,
  input  wire           step_mode,
`endif
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [AW-1:0] issue_idx,
  input  wire  [AW-1:0] res_addr,
  output logic [7:0]    res_data,
  pico_issue_driver_if.master core
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_GAP     = 3'd2,
    S_SETTLE  = 3'd3,
    S_CAPTURE = 3'd4,
    S_HOLD    = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW:0]   len_q, len_d;
  logic [7:0]    wait_q, wait_d;
  logic [2:0]    settle_q, settle_d;
  logic          error_q, error_d;
  logic          done_q, done_d;
  logic [14:0]   instr_q, instr_d;
  logic          prog_wr, res_wr;
  logic          valid;

  logic [14:0]   prog_q [DEPTH];
  logic [7:0]    res_q  [DEPTH];

  // Only the valid bit of the debug byte matters to the driver.
  logic unused_dbg;
  assign unused_dbg = ^{core.core_dbg[7:4], core.core_dbg[2:0]};
  assign valid      = core.core_dbg[3];

  // Next-state, counter and memory-write decisions for the issue sequencer.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    len_d    = len_q;
    wait_d   = wait_q;
    settle_d = settle_q;
    error_d  = error_q;
    done_d   = 1'b0;
    instr_d  = instr_q;
    res_wr   = 1'b0;
    prog_wr  = prog_we && (state_q == S_IDLE);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          error_d = 1'b0;
          if (prog_len == '0) begin
            done_d = 1'b1;
          end else begin
            len_d   = prog_len;
            idx_d   = '0;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        wait_d  = '0;
        state_d = S_GAP;
      end
      S_GAP: begin
        wait_d = wait_q + 8'd1;
        // The first GAP cycle still shows the previous instruction's valid.
        if ((wait_q != 8'd0) && valid) begin
          if (SETTLE == 0) begin
            state_d = S_CAPTURE;
          end else begin
            settle_d = 3'(SETTLE);
            state_d  = S_SETTLE;
          end
        end else if ((wait_q + 8'd1) == 8'(TIMEOUT)) begin
          error_d = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_SETTLE: begin
        if (settle_q <= 3'd1) begin
          state_d = S_CAPTURE;
        end else begin
          settle_d = settle_q - 3'd1;
        end
      end
      S_CAPTURE: begin
        res_wr = 1'b1;
        // Extra bit on the compare keeps len == DEPTH from wrapping.
        if (({1'b0, idx_q} + (AW+1)'(1)) == len_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          idx_d   = idx_q + AW'(1);
`ifdef STEP_MODE_EN
          state_d = step_mode ? S_HOLD : S_ISSUE;
`else
          state_d = S_ISSUE;
`endif
        end
      end
`ifdef STEP_MODE_EN
      S_HOLD: begin
        if (step) state_d = S_ISSUE;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything except when already idle.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      done_d  = 1'b1;
      res_wr  = 1'b0;
      error_d = error_q;
    end

    // Latch the word on entry to ISSUE so the bits stay put through GAP.
    if (state_d == S_ISSUE) instr_d = prog_q[idx_d];
  end

  // Sequencer state and counters, asynchronously reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      len_q    <= '0;
      wait_q   <= '0;
      settle_q <= '0;
      error_q  <= 1'b0;
      done_q   <= 1'b0;
      instr_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      wait_q   <= wait_d;
      settle_q <= settle_d;
      error_q  <= error_d;
      done_q   <= done_d;
      instr_q  <= instr_d;
    end
  end

  // Program and result memories; contents survive reset.
  always_ff @(posedge clk) begin
    if (prog_wr) prog_q[prog_addr] <= prog_wdata;
    if (res_wr)  res_q[idx_q]      <= core.core_uo;
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign error         = error_q;
  assign issue_idx     = idx_q;
  assign res_data      = res_q[res_addr];
  assign core.core_ui  = {(state_q == S_ISSUE), instr_q[6:0]};
  assign core.core_uio = instr_q[14:7];

endmodule
`default_nettype wire
